tbu: RTL and testbench

//  Traceback unit for the K=3, rate-1/2, 4-state Viterbi decoder. It sits downstream of the ACSU and PMU.
//  It stores the per-step survivor decisions and finds the best state from the normalized path metrics.
//  It traces back 2*TBL steps and emits TBL decoded bits per block, oldest bit first, over a valid/ready stream.

---
 rtl/tbu.sv | 162 ++++++++++++++++
 tb/tb_tbu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tbu.sv
// Traceback unit for the K=3, rate-1/2, 4-state Viterbi decoder.
// Stores survivor decisions in a ring, traces back 2*TBL steps and streams TBL bits per block, oldest first.
module tbu #(
  parameter int TBL      = 32,
  parameter int PM_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [3:0]          dec_i,
  input  logic [PM_WIDTH-1:0] pm_s0_i,
  input  logic [PM_WIDTH-1:0] pm_s1_i,
  input  logic [PM_WIDTH-1:0] pm_s2_i,
  input  logic [PM_WIDTH-1:0] pm_s3_i,
  output logic                bit_o,
  output logic                bit_valid_o,
  input  logic                bit_ready_i
);

  localparam int DEPTH = 2 * TBL;
  localparam int AW    = $clog2(DEPTH);
  localparam int OW    = $clog2(TBL);

  typedef enum logic [1:0] {FILL, START, TRACE, OUTPUT} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   step_q, step_d;
  logic [AW:0]     fill_cnt_q, fill_cnt_d;
  logic            primed_q, primed_d;
  logic [OW-1:0]   rd_idx_q, rd_idx_d;
  logic [1:0]      cur_s_q, cur_s_d;

  logic [3:0]      surv_mem_q [DEPTH];
  logic [TBL-1:0]  outbuf_q;

  logic            wr_en;
  logic            xfer;
  logic [AW:0]     fill_need;
  logic [3:0]      rd_dec;
  logic            ob_we;
  logic            ob_bit;
  logic [OW-1:0]   ob_idx;
  logic [1:0]      best_s;
  logic [PM_WIDTH-1:0] best_pm;

  assign ready_o     = (state_q == FILL) && !rst;
  assign bit_valid_o = (state_q == OUTPUT) && !rst;
  assign bit_o       = bit_valid_o && outbuf_q[rd_idx_q];
  assign wr_en       = valid_i && ready_o;
  assign xfer        = bit_valid_o && bit_ready_i;
  assign rd_dec      = surv_mem_q[addr_q];

  // Until the first traceback has run, the merge window is empty too, so the first block needs twice the writes.
  assign fill_need   = primed_q ? (AW+1)'(TBL) : (AW+1)'(DEPTH);

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    best_s  = 2'd0;
    best_pm = pm_s0_i;
    if (pm_s1_i < best_pm) begin
      best_s  = 2'd1;
      best_pm = pm_s1_i;
    end
    if (pm_s2_i < best_pm) begin
      best_s  = 2'd2;
      best_pm = pm_s2_i;
    end
    if (pm_s3_i < best_pm) begin
      best_s  = 2'd3;
      best_pm = pm_s3_i;
    end
  end

  // NOTE: every output of this block is given a default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    addr_d     = addr_q;
    step_d     = step_q;
    fill_cnt_d = fill_cnt_q;
    primed_d   = primed_q;
    rd_idx_d   = rd_idx_q;
    cur_s_d    = cur_s_q;
    ob_we      = 1'b0;
    ob_bit     = cur_s_q[1];
    ob_idx     = OW'(DEPTH - 1 - int'(step_q));

    unique case (state_q)
      FILL: begin
        if (wr_en) begin
          wp_d       = wp_q + AW'(1);
          fill_cnt_d = fill_cnt_q + (AW+1)'(1);
          if (fill_cnt_d == fill_need) state_d = START;
        end
      end

      START: begin
        cur_s_d = best_s;
        addr_d  = wp_q - AW'(1);
        step_d  = '0;
        state_d = TRACE;
      end

      TRACE: begin
        // Predecessor of {u_t, u_t-1} is {u_t-1, u_t-2}; the stored decision supplies u_t-2.
        cur_s_d = {cur_s_q[0], rd_dec[cur_s_q]};
        addr_d  = addr_q - AW'(1);
        step_d  = step_q + AW'(1);
        ob_we   = (step_q >= AW'(TBL));
        if (step_q == AW'(DEPTH - 1)) state_d = OUTPUT;
      end

      OUTPUT: begin
        if (xfer) begin
          if (rd_idx_q == OW'(TBL - 1)) begin
            primed_d   = 1'b1;
            fill_cnt_d = '0;
            rd_idx_d   = '0;
            state_d    = FILL;
          end else begin
            rd_idx_d = rd_idx_q + OW'(1);
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      wp_q       <= '0;
      addr_q     <= '0;
      step_q     <= '0;
      fill_cnt_q <= '0;
      primed_q   <= 1'b0;
      rd_idx_q   <= '0;
      cur_s_q    <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      addr_q     <= addr_d;
      step_q     <= step_d;
      fill_cnt_q <= fill_cnt_d;
      primed_q   <= primed_d;
      rd_idx_q   <= rd_idx_d;
      cur_s_q    <= cur_s_d;
    end
  end

  // NOTE: the storage arrays have no reset; every entry is written before the FSM can read it.
  always_ff @(posedge clk) begin
    if (wr_en) surv_mem_q[wp_q] <= dec_i;
    if (ob_we) outbuf_q[ob_idx] <= ob_bit;
  end

endmodule

// File: tb/tb_tbu.sv
// Self-checking bench for tbu: noiseless random paths, backpressure, argmin ties, mid-trace reset.
module tb_tbu;

  localparam int TBL    = 32;
  localparam int PMW    = 8;
  localparam int DEPTH  = 2 * TBL;
  localparam int LAT    = 2 * TBL + 1;
  localparam int MAXN   = 160;
  localparam int BUDGET = 20000;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_i;
  logic           ready_o;
  logic [3:0]     dec_i;
  logic [PMW-1:0] pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i;
  logic           bit_o;
  logic           bit_valid_o;
  logic           bit_ready_i;

  always #5 clk = ~clk;

  tbu #(.TBL(TBL), .PM_WIDTH(PMW)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .dec_i       (dec_i),
    .pm_s0_i     (pm_s0_i),
    .pm_s1_i     (pm_s1_i),
    .pm_s2_i     (pm_s2_i),
    .pm_s3_i     (pm_s3_i),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .bit_ready_i (bit_ready_i)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0]     dec_arr [MAXN];
  logic [PMW-1:0] pm_arr  [MAXN][4];
  bit             u_arr   [MAXN];
  bit             exp_q   [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pm(input int idx);
    pm_s0_i = pm_arr[idx][0];
    pm_s1_i = pm_arr[idx][1];
    pm_s2_i = pm_arr[idx][2];
    pm_s3_i = pm_arr[idx][3];
  endtask

  // Noiseless encoder path: the true state always holds metric 0 and a decision pointing at its real predecessor.
  task automatic gen_path(input int n);
    bit u1 = 0, u2 = 0;
    int s;
    logic [3:0] d;
    for (int t = 0; t < n; t++) begin
      u_arr[t] = 1'($urandom_range(1));
      s = 2 * int'(u_arr[t]) + int'(u1);
      d = 4'($urandom);
      d[s] = u2;
      dec_arr[t] = d;
      for (int i = 0; i < 4; i++) pm_arr[t][i] = PMW'($urandom_range(255, 1));
      pm_arr[t][s] = '0;
      u2 = u1;
      u1 = u_arr[t];
    end
  endtask

  // Generic traceback over the recorded decision history, used where the bits are not a known message.
  task automatic ref_block(input int n_done);
    bit blk [TBL];
    int best = 0;
    int s;
    for (int i = 1; i < 4; i++)
      if (pm_arr[n_done-1][i] < pm_arr[n_done-1][best]) best = i;
    s = best;
    for (int k = 0; k < DEPTH; k++) begin
      if (k >= TBL) blk[DEPTH-1-k] = (s >= 2);
      s = 2 * (s % 2) + int'(dec_arr[n_done-1-k][s]);
    end
    for (int i = 0; i < TBL; i++) exp_q.push_back(blk[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_i = 1'b0;
    bit_ready_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_ready_o", ready_o, 0);
      check("rst_bit_valid_o", bit_valid_o, 0);
      check("rst_bit_o", bit_o, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_o", ready_o, 1);
    check("post_rst_bit_valid_o", bit_valid_o, 0);
  endtask

  // Cycle-by-cycle driver and checker; inputs change and outputs are sampled on the falling edge.
  task automatic run_stream(input int n, input bit hold_valid, input int rdy_pct, input bit use_u);
    int wi = 0, blk = 0, cyc = 0, done_cyc = 0, last_acc = -1;
    bit primed = 0, busy = 0, stalled = 0, exp_valid;
    logic prev_bit = 1'b0;
    exp_q.delete();
    while ((wi < n || busy) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (last_acc >= 0) set_pm(last_acc);
      exp_valid = busy && (cyc - done_cyc > LAT);
      check("ready_o", ready_o, !busy);
      check("bit_valid_o", bit_valid_o, exp_valid);
      if (exp_valid) check("bit_o", bit_o, exp_q[0]);
      if (exp_valid && stalled) check("bit_o_hold", bit_o, prev_bit);

      bit_ready_i = ($urandom_range(99) < rdy_pct);
      valid_i     = hold_valid ? (wi < n) : ((wi < n) && ($urandom_range(3) != 0));
      dec_i       = (wi < n) ? dec_arr[wi] : 4'h0;

      if (valid_i && !busy) begin
        last_acc = wi;
        wi++;
        blk++;
        if (blk == (primed ? TBL : DEPTH)) begin
          busy = 1;
          done_cyc = cyc;
          primed = 1;
          blk = 0;
          if (use_u) for (int i = 0; i < TBL; i++) exp_q.push_back(u_arr[wi-DEPTH+i]);
          else ref_block(wi);
        end
      end
      stalled  = exp_valid && !bit_ready_i;
      prev_bit = bit_o;
      if (exp_valid && bit_ready_i) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) busy = 0;
      end
    end
    check("stream_writes", wi, n);
    check("stream_drained", exp_q.size(), 0);
    @(negedge clk);
    valid_i = 1'b0;
    bit_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid_i = 1'b0;
    bit_ready_i = 1'b0;
    dec_i = '0;
    pm_s0_i = '0; pm_s1_i = '0; pm_s2_i = '0; pm_s3_i = '0;

    // All-zero decisions with state 0 clearly best.
    do_reset();
    for (int t = 0; t < 64; t++) begin
      dec_arr[t] = 4'h0;
      pm_arr[t][0] = 8'd0;
      for (int i = 1; i < 4; i++) pm_arr[t][i] = 8'd128;
    end
    run_stream(64, 0, 100, 0);

    // Random message, free-flowing sink.
    gen_path(128);
    do_reset();
    run_stream(128, 0, 100, 1);

    // Same message, sink ready about half the time.
    do_reset();
    run_stream(128, 0, 50, 1);

    // Same message, valid_i held high through trace and output.
    do_reset();
    run_stream(128, 1, 70, 1);

    // Non-merging decisions so the start state is visible: all-equal metrics, then {9,3,3,5}.
    do_reset();
    for (int t = 0; t < 96; t++) begin
      dec_arr[t] = 4'b1100;
      for (int i = 0; i < 4; i++) pm_arr[t][i] = PMW'($urandom_range(255));
    end
    for (int i = 0; i < 4; i++) pm_arr[63][i] = 8'd7;
    pm_arr[95][0] = 8'd9; pm_arr[95][1] = 8'd3; pm_arr[95][2] = 8'd3; pm_arr[95][3] = 8'd5;
    run_stream(96, 0, 100, 0);

    // Reset in the middle of a traceback.
    gen_path(64);
    do_reset();
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      valid_i = 1'b1;
      dec_i = dec_arr[t];
      set_pm(t);
    end
    @(negedge clk);
    valid_i = 1'b0;
    check("full_ready_o", ready_o, 0);
    repeat (20) @(negedge clk);
    check("mid_trace_bit_valid_o", bit_valid_o, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("release_bit_valid_o", bit_valid_o, 0);
    check("release_ready_o", ready_o, 1);
    gen_path(64);
    run_stream(64, 0, 80, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
